// File: rtl/window3x3.sv
// -----------------------------------------------------------------------------
// window3x3
// Builds a 3x3 neighbourhood of HSV pixels from a raster pixel stream. One
// window is produced per accepted pixel. The bottom-right corner of the window
// is the pixel just accepted, so the centre lags by one line plus one pixel.
// A parallel pass-stream is delayed so that it stays aligned with the window
// centre.
//
// Ports
//   clk        in   pixel clock
//   rst        in   asynchronous active-low reset
//   in_valid   in   col/row/pixel_in/pass_in are valid this cycle
//   col        in   column of the incoming pixel (0..LINE_W-1)
//   row        in   row of the incoming pixel
//   pixel_in   in   processed-stream pixel
//   pass_in    in   unprocessed pass-stream pixel
//   win_out    out  slot k = [k*PIX_W +: PIX_W], k = 3*r + c,
//                   r0 = oldest line, c0 = oldest column
//   win_valid  out  win_out holds a complete interior window
//   center_out out  win_out slot 4
//   pass_thru  out  pass-stream pixel at the window-centre position
// -----------------------------------------------------------------------------
module window3x3 #(
   parameter int PIX_W  = 24,
   parameter int LINE_W = 640,
   parameter int COL_W  = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [COL_W-1:0]   col,
   input  logic [COL_W-1:0]   row,
   input  logic [PIX_W-1:0]   pixel_in,
   input  logic [PIX_W-1:0]   pass_in,
   output logic [9*PIX_W-1:0] win_out,
   output logic               win_valid,
   output logic [PIX_W-1:0]   center_out,
   output logic [PIX_W-1:0]   pass_thru
);

   localparam int               ADDR_W     = (LINE_W > 1) ? $clog2(LINE_W) : 1;
   localparam logic [COL_W:0]   LINE_W_EXT = (COL_W+1)'(LINE_W);
   localparam logic [COL_W-1:0] LAST_COL   = COL_W'(LINE_W-1);

   // Extended compare so LINE_W == 2**COL_W still works.
   logic accept;
   assign accept = in_valid && ({1'b0, col} < LINE_W_EXT);

   // col is known to be < LINE_W whenever the address is used.
   logic [ADDR_W-1:0] addr;
   assign addr = col[ADDR_W-1:0];

   // ---------------------------------------------------------------------
   // Line buffers (not reset; stale contents are masked by the counters)
   // ---------------------------------------------------------------------
   logic [PIX_W-1:0] lb0_mem [LINE_W];   // line r-1
   logic [PIX_W-1:0] lb1_mem [LINE_W];   // line r-2
   logic [PIX_W-1:0] plb_mem [LINE_W];   // pass stream, line r-1

   logic [PIX_W-1:0] lb0_rd;
   logic [PIX_W-1:0] lb1_rd;
   logic [PIX_W-1:0] plb_rd;

   // Read-before-write: the old contents feed the window on the same edge
   // that overwrites them.
   assign lb0_rd = lb0_mem[addr];
   assign lb1_rd = lb1_mem[addr];
   assign plb_rd = plb_mem[addr];

   always_ff @(posedge clk) begin
      if (accept) begin
         lb0_mem[addr] <= pixel_in;
         lb1_mem[addr] <= lb0_rd;
         plb_mem[addr] <= pass_in;
      end
   end

   // ---------------------------------------------------------------------
   // Window shift registers: each line shifts toward slot c0 and the
   // newest column is filled with {line r-2, line r-1, current pixel}.
   // ---------------------------------------------------------------------
   logic [PIX_W-1:0]   new_col [3];
   logic [9*PIX_W-1:0] win_q;
   logic [9*PIX_W-1:0] win_d;
   logic [9*PIX_W-1:0] win_shift;

   assign new_col[0] = lb1_rd;
   assign new_col[1] = lb0_rd;
   assign new_col[2] = pixel_in;

   genvar gi;
   generate
      for (gi = 0; gi < 9; gi++) begin : g_slot
         if ((gi % 3) == 2) begin : g_newest
            assign win_shift[gi*PIX_W +: PIX_W] = new_col[gi/3];
         end else begin : g_older
            assign win_shift[gi*PIX_W +: PIX_W] = win_q[(gi+1)*PIX_W +: PIX_W];
         end
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Pass path, counters and window-valid flag
   // ---------------------------------------------------------------------
   logic [PIX_W-1:0] pass_dly_q, pass_dly_d;
   logic [PIX_W-1:0] pass_thru_q, pass_thru_d;
   logic [1:0]       cols_seen_q, cols_seen_d;
   logic [1:0]       lines_filled_q, lines_filled_d;
   logic             win_valid_q, win_valid_d;

   always_comb begin
      win_d          = win_q;
      pass_dly_d     = pass_dly_q;
      pass_thru_d    = pass_thru_q;
      cols_seen_d    = cols_seen_q;
      lines_filled_d = lines_filled_q;
      win_valid_d    = win_valid_q;
      if (accept) begin
         win_d = win_shift;
         // plb holds line r-1 at this column; one more accept of delay puts
         // it at (r-1, c-1), the window centre.
         pass_thru_d = pass_dly_q;
         pass_dly_d  = plb_rd;

         if (col == '0) begin
            cols_seen_d = 2'd0;
         end else if (cols_seen_q != 2'd2) begin
            cols_seen_d = cols_seen_q + 2'd1;
         end

         if ((row == '0) && (col == '0)) begin
            lines_filled_d = 2'd0;
         end else if ((col == LAST_COL) && (lines_filled_q != 2'd2)) begin
            lines_filled_d = lines_filled_q + 2'd1;
         end

         // cols_seen_d == 2 means the shift registers now hold three columns
         // of the current line; two completed lines must precede it.
         win_valid_d = (lines_filled_q == 2'd2) && (cols_seen_d == 2'd2);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_q          <= '0;
         pass_dly_q     <= '0;
         pass_thru_q    <= '0;
         cols_seen_q    <= '0;
         lines_filled_q <= '0;
         win_valid_q    <= 1'b0;
      end else begin
         win_q          <= win_d;
         pass_dly_q     <= pass_dly_d;
         pass_thru_q    <= pass_thru_d;
         cols_seen_q    <= cols_seen_d;
         lines_filled_q <= lines_filled_d;
         win_valid_q    <= win_valid_d;
      end
   end

   assign win_out    = win_q;
   assign center_out = win_q[4*PIX_W +: PIX_W];
   assign pass_thru  = pass_thru_q;
   assign win_valid  = win_valid_q;

endmodule

// File: tb/tb_window3x3.sv
module tb_window3x3;

   localparam int PIX_W  = 24;
   localparam int LINE_W = 8;
   localparam int COL_W  = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic [COL_W-1:0]   col = '0;
   logic [COL_W-1:0]   row = '0;
   logic [PIX_W-1:0]   pixel_in = '0;
   logic [PIX_W-1:0]   pass_in = '0;
   logic [9*PIX_W-1:0] win_out;
   logic               win_valid;
   logic [PIX_W-1:0]   center_out;
   logic [PIX_W-1:0]   pass_thru;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   window3x3 #(.PIX_W(PIX_W), .LINE_W(LINE_W), .COL_W(COL_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .col(col), .row(row),
      .pixel_in(pixel_in), .pass_in(pass_in), .win_out(win_out),
      .win_valid(win_valid), .center_out(center_out), .pass_thru(pass_thru)
   );

   // ---------------- comparison helpers ----------------
   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic chkp(input string name, input logic [PIX_W-1:0] act, input logic [PIX_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %06h expected %06h", name, act, exp);
      end
   endtask

   task automatic chkw(input string name, input logic [9*PIX_W-1:0] act, input logic [9*PIX_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Each column remembers the two most recent pixels seen there and the most
   // recent pass pixel. The window is a 3x3 array of (value, known) cells.
   logic [PIX_W-1:0] m_win [9];
   bit               m_wk  [9];
   logic [PIX_W-1:0] h0 [LINE_W];
   logic [PIX_W-1:0] h1 [LINE_W];
   logic [PIX_W-1:0] ph [LINE_W];
   bit               h0k [LINE_W];
   bit               h1k [LINE_W];
   bit               phk [LINE_W];
   logic [PIX_W-1:0] m_pprev, m_pass;
   bit               m_pprevk, m_passk;
   int               m_run, m_lines;
   bit               m_valid;

   task automatic model_reset();
      for (int k = 0; k < 9; k++) begin
         m_win[k] = '0;
         m_wk[k]  = 1'b1;
      end
      m_pprev = '0; m_pprevk = 1'b1;
      m_pass  = '0; m_passk  = 1'b1;
      m_run = 0; m_lines = 0; m_valid = 1'b0;
   endtask

   task automatic model_accept(input int c, input int r, input logic [PIX_W-1:0] p, input logic [PIX_W-1:0] q);
      logic [PIX_W-1:0] nc [3];
      bit               nk [3];
      int               lines_before;
      nc[0] = h1[c]; nk[0] = h1k[c];
      nc[1] = h0[c]; nk[1] = h0k[c];
      nc[2] = p;     nk[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         m_win[3*i]   = m_win[3*i+1]; m_wk[3*i]   = m_wk[3*i+1];
         m_win[3*i+1] = m_win[3*i+2]; m_wk[3*i+1] = m_wk[3*i+2];
         m_win[3*i+2] = nc[i];        m_wk[3*i+2] = nk[i];
      end
      h1[c] = h0[c]; h1k[c] = h0k[c];
      h0[c] = p;     h0k[c] = 1'b1;
      // pass value lags one line (per-column store) plus one accepted pixel
      m_pass = m_pprev; m_passk = m_pprevk;
      m_pprev = ph[c];  m_pprevk = phk[c];
      ph[c] = q;        phk[c] = 1'b1;
      lines_before = m_lines;
      if (r == 0 && c == 0) m_lines = 0;
      else if (c == LINE_W-1) m_lines++;
      if (c == 0) m_run = 1;
      else m_run++;
      m_valid = (lines_before >= 2) && (m_run >= 3);
   endtask

   task automatic model_check(input string tag);
      chk1($sformatf("%s.m_valid", tag), win_valid, m_valid);
      for (int k = 0; k < 9; k++)
         if (m_wk[k]) chkp($sformatf("%s.m_slot%0d", tag, k), win_out[k*PIX_W +: PIX_W], m_win[k]);
      if (m_wk[4]) chkp($sformatf("%s.m_center", tag), center_out, m_win[4]);
      if (m_passk) chkp($sformatf("%s.m_pass", tag), pass_thru, m_pass);
   endtask

   // One clock of stimulus, then model update and model comparison.
   task automatic step(input logic v, input int c, input int r,
                       input logic [PIX_W-1:0] p, input logic [PIX_W-1:0] q, input string tag);
      in_valid = v; col = c[COL_W-1:0]; row = r[COL_W-1:0]; pixel_in = p; pass_in = q;
      @(posedge clk);
      #1;
      if (v && c < LINE_W) model_accept(c, r, p, q);
      model_check(tag);
      $display("txn %s v=%0b col=%0d row=%0d win_valid=%0b center=%06h pass=%06h",
               tag, v, c, r, win_valid, center_out, pass_thru);
   endtask

   task automatic do_reset(input string tag);
      #2 rst = 1'b0;
      #1;
      chkw($sformatf("%s.rst_win", tag), win_out, '0);
      chk1($sformatf("%s.rst_valid", tag), win_valid, 1'b0);
      chkp($sformatf("%s.rst_center", tag), center_out, '0);
      chkp($sformatf("%s.rst_pass", tag), pass_thru, '0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic             v;
      int               c;
      int               r;
      logic [PIX_W-1:0] p;
      logic [PIX_W-1:0] q;
      logic             ev;
      logic             cw;
      logic [PIX_W-1:0] s0, s4, s8, ep;
   } vec_t;

   function automatic logic [PIX_W-1:0] px(input int r, input int c);
      return PIX_W'((r << 8) | c);
   endfunction

   // Raster pixel with coordinate-derived expectations.
   function automatic vec_t rast(input int r, input int c, input logic [PIX_W-1:0] base);
      vec_t v;
      v.v = 1'b1; v.c = c; v.r = r;
      v.p = base | px(r, c);
      v.q = ~v.p;
      v.ev = (r >= 2) && (c >= 2);
      v.cw = v.ev;
      v.s0 = '0; v.s4 = '0; v.s8 = '0; v.ep = '0;
      if (r >= 2 && c >= 2) begin
         v.s0 = base | px(r-2, c-2);
         v.s4 = base | px(r-1, c-1);
         v.s8 = v.p;
         v.ep = ~(base | px(r-1, c-1));
      end
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input string tag);
      step(v.v, v.c, v.r, v.p, v.q, tag);
      chk1($sformatf("%s.valid", tag), win_valid, v.ev);
      if (v.cw) begin
         chkp($sformatf("%s.slot0", tag), win_out[0*PIX_W +: PIX_W], v.s0);
         chkp($sformatf("%s.slot4", tag), win_out[4*PIX_W +: PIX_W], v.s4);
         chkp($sformatf("%s.slot8", tag), win_out[8*PIX_W +: PIX_W], v.s8);
         chkp($sformatf("%s.center", tag), center_out, v.s4);
         chkp($sformatf("%s.pass", tag), pass_thru, v.ep);
      end
   endtask

   vec_t tbl[$];

   initial begin
      vec_t v;
      vec_t held;
      logic [PIX_W-1:0] base2;

      for (int c = 0; c < LINE_W; c++) begin
         h0k[c] = 1'b0; h1k[c] = 1'b0; phk[c] = 1'b0;
         h0[c] = '0; h1[c] = '0; ph[c] = '0;
      end

      // Frame 1 rows 0..3; after row 3 col 3: three idle cycles and one
      // out-of-range column, all of which must leave the outputs unchanged.
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < LINE_W; c++) begin
            v = rast(r, c, '0);
            tbl.push_back(v);
            if (r == 3 && c == 3) begin
               held = v;
               for (int g = 0; g < 3; g++) begin
                  held.v = 1'b0; held.c = 5; held.p = 24'h00ABCD; held.q = 24'h00DCBA;
                  tbl.push_back(held);
               end
               held.v = 1'b1; held.c = 9; held.p = 24'hDEAD00; held.q = 24'h0BEEF0;
               tbl.push_back(held);
            end
         end
      end

      // Power-on reset
      #2 rst = 1'b0;
      #1;
      chkw("por.win", win_out, '0);
      chk1("por.valid", win_valid, 1'b0);
      chkp("por.center", center_out, '0);
      chkp("por.pass", pass_thru, '0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

      // Row 4 up to col 3, then reset mid-line
      for (int c = 0; c < 4; c++) run_vec(rast(4, c, '0), $sformatf("f1r4c%0d", c));
      do_reset("midframe");
      for (int r = 4; r < LINE_W; r++) begin
         for (int c = (r == 4) ? 4 : 0; c < LINE_W; c++) begin
            v = rast(r, c, '0);
            v.ev = (r >= 6) && (c >= 2);
            v.cw = v.ev;
            run_vec(v, $sformatf("post_rst_r%0dc%0d", r, c));
         end
      end

      // Frame 2 directly after frame 1: start-of-frame clears the line count
      base2 = 24'h100000;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < LINE_W; c++)
            run_vec(rast(r, c, base2), $sformatf("f2r%0dc%0d", r, c));

      // Randomised frames with gaps, illegal columns and occasional resets
      for (int f = 0; f < 6; f++) begin
         int nrows;
         nrows = int'($urandom_range(3, 6));
         for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < LINE_W; c++) begin
               if ($urandom_range(0, 3) == 0) begin
                  int ng;
                  ng = int'($urandom_range(1, 3));
                  for (int g = 0; g < ng; g++)
                     step(1'b0, int'($urandom_range(0, 15)), r, PIX_W'($urandom), PIX_W'($urandom), "rnd_gap");
               end
               if ($urandom_range(0, 19) == 0)
                  step(1'b1, int'($urandom_range(8, 15)), r, PIX_W'($urandom), PIX_W'($urandom), "rnd_badcol");
               if ($urandom_range(0, 149) == 0) do_reset("rnd_rst");
               step(1'b1, c, r, PIX_W'($urandom), PIX_W'($urandom), $sformatf("rnd_f%0dr%0dc%0d", f, r, c));
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
